ntt_seq_ctrl: RTL and testbench

- Upstream sequencer for the radix-2 4-BFU NTT index FSM.
- Accepts a one-cycle start command with an operation code and drives the FSM's 3-bit conf input through run and pipeline-drain phases.
- Watches the FSM's done_flag and reports completion, timeout and rejected commands to the host.
- Supports single NTT, PWM or INTT, or the chained sequence NTT -> PWM -> INTT.

---
 rtl/ntt_pkg.sv | 54 +++++
 rtl/ntt_seq_ctrl_if.sv | 26 ++
 rtl/ntt_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared codes for the NTT sequencer: index-FSM conf codes, host op codes,
// done_flag masks and sequencer state encodings.
package ntt_pkg;

    localparam int unsigned CONF_W = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DF_W   = 4;
    localparam int unsigned ST_W   = 2;

    localparam logic [CONF_W-1:0] CONF_IDLE      = 3'd0;
    localparam logic [CONF_W-1:0] CONF_NTT       = 3'd1;
    localparam logic [CONF_W-1:0] CONF_PWM       = 3'd2;
    localparam logic [CONF_W-1:0] CONF_INTT      = 3'd3;
    localparam logic [CONF_W-1:0] CONF_DONE_NTT  = 3'd4;
    localparam logic [CONF_W-1:0] CONF_DONE_INTT = 3'd5;

    localparam logic [OP_W-1:0] OP_NTT   = 2'd0;
    localparam logic [OP_W-1:0] OP_PWM   = 2'd1;
    localparam logic [OP_W-1:0] OP_INTT  = 2'd2;
    localparam logic [OP_W-1:0] OP_CHAIN = 2'd3;

    localparam logic [DF_W-1:0] DF_NTT  = 4'b0001;
    localparam logic [DF_W-1:0] DF_PWM  = 4'b0010;
    localparam logic [DF_W-1:0] DF_INTT = 4'b0100;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // Run-phase conf code; CHAIN always starts with the NTT phase.
    function automatic logic [CONF_W-1:0] op_run_conf(input logic [OP_W-1:0] op);
        case (op)
            OP_PWM:  return CONF_PWM;
            OP_INTT: return CONF_INTT;
            default: return CONF_NTT;
        endcase
    endfunction

    function automatic logic [CONF_W-1:0] op_drain_conf(input logic [OP_W-1:0] op);
        return (op == OP_INTT) ? CONF_DONE_INTT : CONF_DONE_NTT;
    endfunction

    function automatic logic [DF_W-1:0] op_done_mask(input logic [OP_W-1:0] op);
        case (op)
            OP_PWM:  return DF_PWM;
            OP_INTT: return DF_INTT;
            default: return DF_NTT;
        endcase
    endfunction

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Host command / index-FSM handshake bundle for ntt_seq_ctrl.
interface ntt_seq_ctrl_if;
    import ntt_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op;
    logic              abort;
    logic [DF_W-1:0]   done_flag;
    logic [CONF_W-1:0] conf;
    logic              busy;
    logic              done;
    logic [OP_W-1:0]   done_op;
    logic              reject;
    logic              err;

    modport master (
        output start, op, abort, done_flag,
        input  conf, busy, done, done_op, reject, err
    );

    modport slave (
        input  start, op, abort, done_flag,
        output conf, busy, done, done_op, reject, err
    );

endinterface

// File: rtl/ntt_seq_ctrl.sv
// Sequences the NTT index FSM through run and drain phases for single or
// chained (NTT -> PWM -> INTT) commands, with timeout and abort handling.
module ntt_seq_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 2047,
    parameter int unsigned CNT_W          = 11
) (
    input logic         clk,
    input logic         rst,
    ntt_seq_ctrl_if.slave bus
);

    // Last RUN cycle before timeout and last DRAIN cycle, as counter values.
    localparam logic [CNT_W-1:0] CNT_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DR_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t            state_q,   state_n;
    logic [CNT_W-1:0]  cnt_q,     cnt_n;
    logic [OP_W-1:0]   cur_op_q,  cur_op_n;
    logic [OP_W-1:0]   cmd_op_q,  cmd_op_n;
    logic [1:0]        chain_q,   chain_n;
    logic [CONF_W-1:0] conf_q,    conf_n;
    logic              busy_q,    busy_n;
    logic              done_q,    done_n;
    logic [OP_W-1:0]   done_op_q, done_op_n;
    logic              reject_q,  reject_n;
    logic              err_q,     err_n;

    logic [OP_W-1:0]   next_op;

    // Next phase of a chain: PWM after NTT, INTT after PWM.
    assign next_op = (chain_q == 2'd0) ? OP_PWM : OP_INTT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_op_q  <= OP_NTT;
            cmd_op_q  <= OP_NTT;
            chain_q   <= 2'd0;
            conf_q    <= CONF_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_op_q <= OP_NTT;
            reject_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            cur_op_q  <= cur_op_n;
            cmd_op_q  <= cmd_op_n;
            chain_q   <= chain_n;
            conf_q    <= conf_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            done_op_q <= done_op_n;
            reject_q  <= reject_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        cur_op_n  = cur_op_q;
        cmd_op_n  = cmd_op_q;
        chain_n   = chain_q;
        conf_n    = conf_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        done_op_n = done_op_q;
        reject_n  = 1'b0;
        err_n     = err_q;

        if (bus.abort) begin
            state_n = S_IDLE;
            conf_n  = CONF_IDLE;
            busy_n  = 1'b0;
            cnt_n   = '0;
            chain_n = 2'd0;
        end else begin
            // Any start outside S_IDLE is dropped and flagged.
            if (bus.start && (state_q != S_IDLE)) begin
                reject_n = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_n  = S_RUN;
                        cmd_op_n = bus.op;
                        cur_op_n = (bus.op == OP_CHAIN) ? OP_NTT : bus.op;
                        conf_n   = op_run_conf(bus.op);
                        cnt_n    = '0;
                        chain_n  = 2'd0;
                        err_n    = 1'b0;
                        busy_n   = 1'b1;
                    end
                end

                S_RUN: begin
                    if (bus.done_flag == op_done_mask(cur_op_q)) begin
                        state_n = S_DRAIN;
                        conf_n  = op_drain_conf(cur_op_q);
                        cnt_n   = '0;
                    end else if (cnt_q == CNT_TO_LAST) begin
                        state_n = S_DRAIN;
                        conf_n  = op_drain_conf(cur_op_q);
                        cnt_n   = '0;
                        err_n   = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (cnt_q == CNT_DR_LAST) begin
                        if ((cmd_op_q == OP_CHAIN) && !err_q && (chain_q < 2'd2)) begin
                            state_n  = S_RUN;
                            chain_n  = chain_q + 2'd1;
                            cur_op_n = next_op;
                            conf_n   = op_run_conf(next_op);
                            cnt_n    = '0;
                        end else begin
                            state_n   = S_DONE;
                            conf_n    = CONF_IDLE;
                            busy_n    = 1'b0;
                            done_n    = 1'b1;
                            done_op_n = cmd_op_q;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state_n = S_IDLE;
                    chain_n = 2'd0;
                    cnt_n   = '0;
                end

                default: begin
                    state_n = S_IDLE;
                    conf_n  = CONF_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    assign bus.conf    = conf_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_op = done_op_q;
    assign bus.reject  = reject_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Self-checking bench for ntt_seq_ctrl: an index-FSM stand-in answers conf with
// done_flag after chosen latencies; the conf trace is compared against phase lists.
module tb_ntt_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ntt_seq_ctrl_if bus ();

    ntt_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command end to end. lat[i] is the run cycle (1-based) on which phase i
    // reports completion; 0 means never (timeout). rej_at injects a busy start.
    task automatic run_cmd(input string name, input int op, input int l0, input int l1,
                           input int l2, input int rej_at);
        int lat[3];
        int runs[$];
        int exp_code[$], exp_len[$], got_code[$], got_len[$];
        int exp_err, k, phase, prev, c, rej_cnt, rej_pend, busy_bad, done_seen;
        int got_dop, got_err, conf_done, busy_done, nz, mask;
        logic [3:0] df;
        lat = '{l0, l1, l2};
        exp_err = 0;
        if (op == 3) begin runs.push_back(1); runs.push_back(2); runs.push_back(3); end
        else runs.push_back(op + 1);
        foreach (runs[i]) begin
            int len;
            bit timed;
            timed = (lat[i] == 0) || (lat[i] > 2047);
            len = timed ? 2047 : lat[i];
            exp_code.push_back(runs[i]);             exp_len.push_back(len);
            exp_code.push_back(runs[i] == 3 ? 5 : 4); exp_len.push_back(10);
            if (timed) begin exp_err = 1; break; end
        end

        bus.op = 2'(op);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({name, "_busy_on_start"}, int'(bus.busy), 1);
        check({name, "_err_cleared"}, int'(bus.err), 0);

        prev = 0; phase = -1; k = 0; rej_cnt = 0; rej_pend = 0; busy_bad = 0;
        done_seen = 0; got_dop = -1; got_err = -1; conf_done = -1; busy_done = -1;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            c = int'(bus.conf);
            rej_cnt += int'(bus.reject);
            if (rej_pend != 0) begin
                check({name, "_reject_pulse"}, int'(bus.reject), 1);
                bus.start = 1'b0;
                rej_pend = 0;
            end
            if (bus.done) begin
                done_seen = 1; got_dop = int'(bus.done_op); got_err = int'(bus.err);
                conf_done = c; busy_done = int'(bus.busy);
                break;
            end
            if (!bus.busy) busy_bad++;
            if (got_code.size() == 0 || got_code[$] != c) begin
                got_code.push_back(c); got_len.push_back(1);
            end else begin
                got_len[got_len.size()-1] = got_len[$] + 1;
            end
            df = 4'd0;
            if (c >= 1 && c <= 3) begin
                if (c != prev) begin k = 1; phase++; end
                else k++;
                mask = 1 << (c - 1);
                if (phase < 3 && lat[phase] != 0 && k == lat[phase]) begin
                    df = 4'(mask);
                end else begin
                    nz = int'($urandom_range(0, 15));
                    if (nz != mask && $urandom_range(0, 7) == 0) df = 4'(nz);
                end
                if (rej_at > 0 && phase == 0 && k == rej_at) begin
                    bus.start = 1'b1; bus.op = 2'd2; rej_pend = 1;
                end
            end else if (c == 5) begin
                df = 4'b0001;
            end else if (c == 4) begin
                df = 4'($urandom);
            end
            bus.done_flag = df;
            prev = c;
            step();
        end
        bus.done_flag = 4'd0;
        bus.start = 1'b0;

        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_done_op"}, got_dop, op);
        check({name, "_err_at_done"}, got_err, exp_err);
        check({name, "_conf_idle_at_done"}, conf_done, 0);
        check({name, "_busy_low_at_done"}, busy_done, 0);
        check({name, "_busy_gaps"}, busy_bad, 0);
        check({name, "_reject_count"}, rej_cnt, (rej_at > 0) ? 1 : 0);
        check({name, "_seg_count"}, got_code.size(), exp_code.size());
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            check($sformatf("%s_seg%0d_code", name, i), got_code[i], exp_code[i]);
            check($sformatf("%s_seg%0d_len", name, i), got_len[i], exp_len[i]);
        end
        step();
        check({name, "_done_one_cycle"}, int'(bus.done), 0);
        check({name, "_done_op_held"}, int'(bus.done_op), op);
        check({name, "_err_held"}, int'(bus.err), exp_err);
        check({name, "_idle_conf"}, int'(bus.conf), 0);
    endtask

    // NTT run matched at cycle 50, aborted on its third drain cycle.
    task automatic abort_test();
        int k, d, dones, reached;
        bus.op = 2'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        k = 0; d = 0; reached = 0;
        for (int cyc = 0; cyc < 3000 && reached == 0; cyc++) begin
            bus.done_flag = 4'd0;
            if (bus.conf == 3'd1) begin
                k++;
                if (k == 50) bus.done_flag = 4'b0001;
            end else if (bus.conf == 3'd4) begin
                d++;
                if (d == 3) begin
                    bus.abort = 1'b1;
                    reached = 1;
                end
            end
            step();
        end
        bus.abort = 1'b0;
        bus.done_flag = 4'd0;
        check("abort_reached", reached, 1);
        check("abort_conf_idle", int'(bus.conf), 0);
        check("abort_busy_low", int'(bus.busy), 0);
        check("abort_err_unchanged", int'(bus.err), 0);
        dones = int'(bus.done);
        for (int i = 0; i < 30; i++) begin
            step();
            dones += int'(bus.done);
        end
        check("abort_no_done", dones, 0);
        check("abort_still_idle", int'(bus.conf), 0);
    endtask

    initial begin
        int rop, rl[3], rrej;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.abort = 1'b0;
        bus.done_flag = 4'd0;
        step();
        step();
        check("reset_conf", int'(bus.conf), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst = 1'b0;
        step();
        check("post_reset_conf", int'(bus.conf), 0);
        check("post_reset_busy", int'(bus.busy), 0);
        check("post_reset_done", int'(bus.done), 0);
        check("post_reset_done_op", int'(bus.done_op), 0);
        check("post_reset_reject", int'(bus.reject), 0);
        check("post_reset_err", int'(bus.err), 0);

        run_cmd("ntt", 0, 1280, 0, 0, 0);
        run_cmd("intt", 2, 1280, 0, 0, 0);
        run_cmd("chain", 3, 1280, 128, 1280, 0);
        run_cmd("pwm_timeout", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        check("err_sticky_idle", int'(bus.err), 1);
        run_cmd("ntt_busy_start", 0, 300, 0, 0, 5);
        run_cmd("pwm_match_at_limit", 1, 2047, 0, 0, 0);
        run_cmd("ntt_lat1", 0, 1, 0, 0, 0);
        run_cmd("chain_timeout_pwm", 3, 100, 0, 40, 0);

        abort_test();

        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.op = 2'd1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_start_busy", int'(bus.busy), 0);
        check("abort_start_reject", int'(bus.reject), 0);
        check("abort_start_conf", int'(bus.conf), 0);
        step();
        check("abort_start_still_idle", int'(bus.busy), 0);

        for (int t = 0; t < 8; t++) begin
            rop = int'($urandom_range(0, 3));
            for (int j = 0; j < 3; j++)
                rl[j] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 400));
            rrej = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (rl[0] != 0 && rrej >= rl[0]) rrej = 0;
            run_cmd($sformatf("rand%0d", t), rop, rl[0], rl[1], rl[2], rrej);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
